// File: rtl/spsram_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : spsram_arb_if
//  Purpose  : Bus bundle between two clients, the spsram_arb arbiter and a
//             single-port SRAM. The slave modport is the arbiter's view and
//             the master modport is the view of the surrounding logic.
//  Revision : 1.0 - initial release
// ============================================================================
interface spsram_arb_if #(
    parameter int BW_DATA = 64,
    parameter int BW_ADDR = 6
);
    // Client 0 command and response
    logic               i_req0_valid;
    logic               i_req0_wen;
    logic [BW_ADDR-1:0] i_req0_addr;
    logic [BW_DATA-1:0] i_req0_data;
    logic               o_req0_ready;
    logic               o_req0_rvalid;
    logic [BW_DATA-1:0] o_req0_rdata;

    // Client 1 command and response
    logic               i_req1_valid;
    logic               i_req1_wen;
    logic [BW_ADDR-1:0] i_req1_addr;
    logic [BW_DATA-1:0] i_req1_data;
    logic               o_req1_ready;
    logic               o_req1_rvalid;
    logic [BW_DATA-1:0] o_req1_rdata;

    // SRAM side
    logic               o_sram_cen;
    logic               o_sram_wen;
    logic               o_sram_oen;
    logic [BW_ADDR-1:0] o_sram_addr;
    logic [BW_DATA-1:0] o_sram_data;
    logic [BW_DATA-1:0] i_sram_data;

    modport slave (
        input  i_req0_valid, i_req0_wen, i_req0_addr, i_req0_data,
        output o_req0_ready, o_req0_rvalid, o_req0_rdata,
        input  i_req1_valid, i_req1_wen, i_req1_addr, i_req1_data,
        output o_req1_ready, o_req1_rvalid, o_req1_rdata,
        output o_sram_cen, o_sram_wen, o_sram_oen, o_sram_addr, o_sram_data,
        input  i_sram_data
    );

    modport master (
        output i_req0_valid, i_req0_wen, i_req0_addr, i_req0_data,
        input  o_req0_ready, o_req0_rvalid, o_req0_rdata,
        output i_req1_valid, i_req1_wen, i_req1_addr, i_req1_data,
        input  o_req1_ready, o_req1_rvalid, o_req1_rdata,
        input  o_sram_cen, o_sram_wen, o_sram_oen, o_sram_addr, o_sram_data,
        output i_sram_data
    );
endinterface
`default_nettype wire

// File: rtl/spsram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : spsram_arb
//  Purpose  : Two-client arbiter and sequencer for one single-port SRAM.
//             Grants one command per cycle, registers the SRAM controls and
//             routes read data back to the issuing client two cycles after
//             the accept edge.
//  Config   : SPSRAM_ARB_RR_EN defined   -> round-robin tie break via ptr
//             SPSRAM_ARB_RR_EN undefined -> client 0 always wins a tie
//  Revision : 1.0 - initial release
// ============================================================================
module spsram_arb #(
    parameter int BW_DATA = 64,
    parameter int BW_ADDR = 6
) (
    input  logic          i_clk,
    input  logic          i_rst,
    spsram_arb_if.slave   bus
);

    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_accept;
    logic               w_cmd_wen;
    logic [BW_ADDR-1:0] w_cmd_addr;
    logic [BW_DATA-1:0] w_cmd_data;

    // Issue stage
    logic               r_cen;
    logic               r_wen;
    logic               r_oen;
    logic [BW_ADDR-1:0] r_addr;
    logic [BW_DATA-1:0] r_data;
    logic               r_tag;
    logic               r_rd_pend;

    // SRAM access stage: the read is being sampled by the SRAM this cycle
    logic               r_rsp_pend;
    logic               r_rsp_tag;

    // Response stage
    logic               r_rvalid0;
    logic               r_rvalid1;
    logic [BW_DATA-1:0] r_rdata0;
    logic [BW_DATA-1:0] r_rdata1;

`ifdef SPSRAM_ARB_RR_EN
    logic               r_ptr;

    // Client 1 wins when alone or when the pointer favours it in a tie
    assign w_gnt1 = ~i_rst & bus.i_req1_valid & (~bus.i_req0_valid | r_ptr);

    // Pointer moves to the client that lost (or was absent) on every accept
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= w_gnt0;
        end
    end
`else
    // Fixed priority: client 1 only when client 0 is idle
    assign w_gnt1 = ~i_rst & bus.i_req1_valid & ~bus.i_req0_valid;
`endif

    // Ready is held low during reset so nothing is accepted while flushing
    assign w_gnt0   = ~i_rst & bus.i_req0_valid & ~w_gnt1;
    assign w_accept = w_gnt0 | w_gnt1;

    assign w_cmd_wen  = w_gnt1 ? bus.i_req1_wen  : bus.i_req0_wen;
    assign w_cmd_addr = w_gnt1 ? bus.i_req1_addr : bus.i_req0_addr;
    assign w_cmd_data = w_gnt1 ? bus.i_req1_data : bus.i_req0_data;

    // Issue stage: register the granted command towards the SRAM
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cen     <= 1'b0;
            r_wen     <= 1'b0;
            r_oen     <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_tag     <= 1'b0;
            r_rd_pend <= 1'b0;
        end else begin
            r_cen     <= w_accept;
            r_wen     <= w_accept & w_cmd_wen;
            r_oen     <= w_accept & ~w_cmd_wen;
            r_rd_pend <= w_accept & ~w_cmd_wen;
            if (w_accept) begin
                r_addr <= w_cmd_addr;
                r_data <= w_cmd_data;
                r_tag  <= w_gnt1;
            end
        end
    end

    // Track the read through the SRAM's own sampling edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_pend <= 1'b0;
            r_rsp_tag  <= 1'b0;
        end else begin
            r_rsp_pend <= r_rd_pend;
            r_rsp_tag  <= r_tag;
        end
    end

    // Response stage: capture SRAM output for the issuing client only
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= r_rsp_pend & ~r_rsp_tag;
            r_rvalid1 <= r_rsp_pend & r_rsp_tag;
            if (r_rsp_pend && !r_rsp_tag) begin
                r_rdata0 <= bus.i_sram_data;
            end
            if (r_rsp_pend && r_rsp_tag) begin
                r_rdata1 <= bus.i_sram_data;
            end
        end
    end

    assign bus.o_req0_ready  = w_gnt0;
    assign bus.o_req1_ready  = w_gnt1;
    assign bus.o_req0_rvalid = r_rvalid0;
    assign bus.o_req1_rvalid = r_rvalid1;
    assign bus.o_req0_rdata  = r_rdata0;
    assign bus.o_req1_rdata  = r_rdata1;
    assign bus.o_sram_cen    = r_cen;
    assign bus.o_sram_wen    = r_wen;
    assign bus.o_sram_oen    = r_oen;
    assign bus.o_sram_addr   = r_addr;
    assign bus.o_sram_data   = r_data;

endmodule
`default_nettype wire

// File: tb/tb_spsram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spsram_arb
//  Purpose  : Self-checking bench for spsram_arb with a behavioural SRAM,
//             a shadow memory and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spsram_arb;

    localparam int c_BW_DATA = 64;
    localparam int c_BW_ADDR = 6;
`ifdef SPSRAM_ARB_RR_EN
    localparam bit c_RR_EN = 1'b1;
`else
    localparam bit c_RR_EN = 1'b0;
`endif

    typedef struct {
        int                   cl;
        logic [c_BW_DATA-1:0] data;
        int                   due;
    } rsp_t;

    logic clk;
    logic rst;

    spsram_arb_if #(.BW_DATA(c_BW_DATA), .BW_ADDR(c_BW_ADDR)) bus ();

    spsram_arb #(.BW_DATA(c_BW_DATA), .BW_ADDR(c_BW_ADDR)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM: write or read on the rising edge
    logic [c_BW_DATA-1:0] sram_mem [1 << c_BW_ADDR];
    always @(posedge clk) begin
        if (bus.o_sram_cen) begin
            if (bus.o_sram_wen) sram_mem[bus.o_sram_addr] <= bus.o_sram_data;
            else                bus.i_sram_data <= sram_mem[bus.o_sram_addr];
        end
    end

    // Expected-state model
    logic [c_BW_DATA-1:0] shadow [1 << c_BW_ADDR];
    rsp_t q [$];
    bit   mptr;
    int   ncyc;
    int   errors;
    int   checks;
    int   last_g;

    task automatic chk(input string tag, input logic [c_BW_DATA-1:0] obs,
                       input logic [c_BW_DATA-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus plus all checks for that cycle
    task automatic cyc(input logic r,
                       input logic v0, input logic w0, input logic [c_BW_ADDR-1:0] a0,
                       input logic [c_BW_DATA-1:0] d0,
                       input logic v1, input logic w1, input logic [c_BW_ADDR-1:0] a1,
                       input logic [c_BW_DATA-1:0] d1);
        int g;
        logic gw;
        logic [c_BW_ADDR-1:0] ga;
        logic [c_BW_DATA-1:0] gd;
        rsp_t e;
        rst = r;
        bus.i_req0_valid = v0; bus.i_req0_wen = w0; bus.i_req0_addr = a0; bus.i_req0_data = d0;
        bus.i_req1_valid = v1; bus.i_req1_wen = w1; bus.i_req1_addr = a1; bus.i_req1_data = d1;
        #1;
        g = -1;
        if (!r) begin
            if (v0 && v1) g = (c_RR_EN && mptr) ? 1 : 0;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        last_g = g;
        chk("ready0", bus.o_req0_ready, (g == 0));
        chk("ready1", bus.o_req1_ready, (g == 1));
        gw = (g == 1) ? w1 : w0;
        ga = (g == 1) ? a1 : a0;
        gd = (g == 1) ? d1 : d0;
        if (g >= 0) begin
            if (gw) shadow[ga] = gd;
            else    q.push_back('{g, shadow[ga], ncyc + 3});
            if (c_RR_EN) mptr = (g == 0);
        end
        if (r) begin
            q.delete();
            mptr = 1'b0;
        end
        @(posedge clk);
        #1;
        ncyc++;
        chk("sram_cen", bus.o_sram_cen, (g >= 0));
        chk("sram_wen", bus.o_sram_wen, (g >= 0) && gw);
        chk("sram_oen", bus.o_sram_oen, (g >= 0) && !gw);
        if (g >= 0) begin
            chk("sram_addr", bus.o_sram_addr, ga);
            if (gw) chk("sram_data", bus.o_sram_data, gd);
        end
        if (q.size() > 0 && q[0].due == ncyc) begin
            e = q.pop_front();
            chk("rvalid0", bus.o_req0_rvalid, (e.cl == 0));
            chk("rvalid1", bus.o_req1_rvalid, (e.cl == 1));
            if (e.cl == 0) chk("rdata0", bus.o_req0_rdata, e.data);
            else           chk("rdata1", bus.o_req1_rdata, e.data);
        end else begin
            chk("no_rvalid0", bus.o_req0_rvalid, 1'b0);
            chk("no_rvalid1", bus.o_req1_rvalid, 1'b0);
        end
        if (r) begin
            chk("rst_addr",   bus.o_sram_addr,  '0);
            chk("rst_data",   bus.o_sram_data,  '0);
            chk("rst_rdata0", bus.o_req0_rdata, '0);
            chk("rst_rdata1", bus.o_req1_rdata, '0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ncyc   = 0;
        mptr   = 1'b0;
        last_g = -1;
        bus.i_sram_data = '0;

        // Reset state, with both clients asserting valid
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 1'b0, 6'd3, 64'h1, 1'b1, 1'b0, 6'd4, 64'h2);

        // Contention: both write address i, data = addr + 0x100*id
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 6'(i), 64'(i), 1'b1, 1'b1, 6'(i), 64'(i) + 64'h100);
            chk("cont_grant", last_g, c_RR_EN ? (i % 2) : 0);
        end

        // Single client: write then read the same address back-to-back
        cyc(1'b0, 1'b1, 1'b1, 6'd5, 64'hA5, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 1'b0, 6'd5, '0,     1'b0, 1'b0, '0, '0);
        idle(3);

        // Read routing on consecutive cycles
        cyc(1'b0, 1'b1, 1'b1, 6'd1, 64'h11, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0,   '0,     1'b1, 1'b1, 6'd2, 64'h22);
        cyc(1'b0, 1'b1, 1'b0, 6'd1, '0,     1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0,   '0,     1'b1, 1'b0, 6'd2, '0);
        idle(3);

        // Full address range, data = ~addr; then read the two extremes
        for (int i = 0; i < 64; i++)
            cyc(1'b0, 1'b1, 1'b1, 6'(i), ~64'(i), 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd63, '0);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd0,  '0);
        idle(3);

        // Mixed random traffic over the now fully written memory
        for (int i = 0; i < 60; i++)
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom),
                {$urandom, $urandom},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom),
                {$urandom, $urandom});

        // Idle: no accept, pointer must hold across the gap
        idle(10);
        cyc(1'b0, 1'b1, 1'b0, 6'd7, '0, 1'b1, 1'b0, 6'd8, '0);
        cyc(1'b0, 1'b1, 1'b0, 6'd9, '0, 1'b1, 1'b0, 6'd10, '0);

        // Reset mid-stream with a read in flight: it must never respond
        cyc(1'b0, 1'b1, 1'b0, 6'd5, '0, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 1'b0, 6'd6, '0, 1'b1, 1'b0, 6'd7, '0);
        cyc(1'b1, 1'b1, 1'b0, 6'd6, '0, 1'b1, 1'b0, 6'd7, '0);
        idle(4);
        cyc(1'b0, 1'b1, 1'b0, 6'd11, '0, 1'b1, 1'b0, 6'd12, '0);
        chk("post_rst_grant", last_g, 0);
        cyc(1'b0, 1'b1, 1'b0, 6'd13, '0, 1'b1, 1'b0, 6'd14, '0);
        idle(4);

        chk("sb_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spsram_arb.md
# spsram_arb

Two-requester arbiter and sequencer for one `spsram` instance (BW_DATA x 2^BW_ADDR, single port). It accepts read/write commands from two independent clients over valid/ready handshakes, issues at most one SRAM access per cycle, and routes read data back to the client that issued the read. It sits between the client logic and a single `spsram`; the banked 4x`spsram` subsystem uses one `spsram_arb` per bank.

## Interface

Parameters:
- BW_DATA, 64, data width; must match the attached `spsram`.
- BW_ADDR, 6, address width; must match the attached `spsram`.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req0_valid / i_req1_valid  in  1  client k has a command.
- i_req0_wen / i_req1_wen  in  1  1 = write, 0 = read.
- i_req0_addr / i_req1_addr  in  BW_ADDR  command address.
- i_req0_data / i_req1_data  in  BW_DATA  write data.
- o_req0_ready / o_req1_ready  out  1  command accepted this cycle (grant).
- o_req0_rvalid / o_req1_rvalid  out  1  one-cycle read-data strobe.
- o_req0_rdata / o_req1_rdata  out  BW_DATA  read data, valid with rvalid.
- o_sram_cen, o_sram_wen, o_sram_oen  out  1  SRAM controls; all are registered.
- o_sram_addr  out  BW_ADDR  SRAM address; registered.
- o_sram_data  out  BW_DATA  SRAM write data; registered.
- i_sram_data  in  BW_DATA  SRAM read data (`o_data` of `spsram`).

## Operation

**Grant logic**
- Grant is combinational from the valid inputs and the priority pointer `ptr` (1 bit).
- Only one ready is high in any cycle.
- `o_reqK_ready` can be high only when `i_reqK_valid` is high.
- If exactly one client is valid, that client is granted.
- If both clients are valid, client `ptr` is granted.
- A command is accepted on an edge where valid and ready are both high.
- The arbiter accepts a command every cycle and never stalls on its own account.

**Issue stage (registered at the accept edge)**
- `o_sram_cen` = 1.
- `o_sram_wen` = the command's wen.
- `o_sram_oen` = ~wen.
- `o_sram_addr` and `o_sram_data` take the granted client's values.
- `tag` = client id; `rd_pend` = ~wen.
- With no accept, `o_sram_cen`, `o_sram_wen` and `o_sram_oen` go to 0. Address and data hold their previous values.

**Response stage (registered)**
- When `rd_pend` is set, `i_sram_data` is captured into `o_req{tag}_rdata`, and `o_req{tag}_rvalid` pulses for one cycle.
- The other client's rdata holds its value and its rvalid stays 0.
- Writes produce no response.

**Pointer**
- On every accept, `ptr` moves to the non-granted client.
- With no accept, `ptr` holds.

**Ordering and hazards**
- Responses return in issue order, one per cycle at most.
- A read issued the cycle after a write to the same address returns the new data, because the SRAM is written at the edge before the read samples it.

**Reset**
- Every output is 0.
- `ptr` = 0, `tag` = 0, `rd_pend` = 0.
- An in-flight read at reset is discarded and never produces rvalid.

## Timing

- Accept at edge N.
- SRAM command is visible after edge N and is sampled by `spsram` at edge N+1.
- `spsram` read data is valid after edge N+1.
- rvalid/rdata are registered at edge N+2 and visible during cycle N+2 → N+3.
- Read latency is 2 cycles from the accept edge.
- Throughput is 1 command per cycle total.
- The write is committed to the SRAM array at edge N+1.
- Ready depends combinationally on valid. Clients must not make valid depend on ready.

## Configuration

Macro: `SPSRAM_ARB_RR_EN`.
- **Defined:** round-robin via `ptr`, as above. Under continuous contention the grants alternate 0,1,0,1…
- **Undefined:** fixed priority; client 0 always wins a tie. `ptr` is not implemented. Client 1 is granted only in cycles when `i_req0_valid` = 0.
- Latency, handshake and reset behaviour are identical in both builds.

## Test plan

- **Reset:** assert i_rst mid-stream for 2 cycles with a read outstanding → all outputs 0 and no rvalid afterwards; after release, first grant under contention goes to client 0.
- **Single-client write then read:** client 0 writes addr 5 = 0xA5 and, on the next cycle, reads addr 5 → `o_req0_rvalid` 2 cycles after the read accept, rdata = 0xA5; `o_req1_rvalid` stays 0.
- **Contention:** both clients hold valid for 6 cycles, writing addresses 0..5 with data = addr + 0x100*id.
  - With `SPSRAM_ARB_RR_EN`: grants are 0,1,0,1,0,1.
  - Without it: all 6 grants go to client 0.
- **Read routing:** client 0 reads addr 1 and client 1 reads addr 2 on back-to-back accepted cycles, with memory holding 0x11 at addr 1 and 0x22 at addr 2 → rvalid pulses on consecutive cycles, client 0 first with 0x11, then client 1 with 0x22.
- **Wrap and full range:** write all 64 addresses with data = ~addr, then read 63 then 0 → correct data; o_sram_addr is 6 bits and does not alias.
- **Idle:** no valid for 10 cycles → o_sram_cen = 0, ptr unchanged, no rvalid.
